// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and baud divisor helper.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    // Integer clocks per bit; legal results are 4..65535.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Parameterizable two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling timed from the start-bit edge.
// Optional frame_err output is enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
`ifdef UART_RX_FRAME_ERR_EN
    output logic       frame_err,
`endif
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);

    logic        w_rx_s;
    uart_state_t r_state,     w_state_nxt;
    logic [15:0] r_clk_count, w_count_nxt;
    logic [2:0]  r_bit_index, w_index_nxt;
    logic [7:0]  r_shift,     w_shift_nxt;
    logic [7:0]  r_data,      w_data_nxt;
    logic        r_valid,     w_valid_nxt;
`ifdef UART_RX_FRAME_ERR_EN
    logic        r_frame_err, w_ferr_nxt;
`endif

    // Synchronizer idles high so reset never looks like a start bit.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_clk_count <= '0;
            r_bit_index <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_clk_count <= w_count_nxt;
            r_bit_index <= w_index_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err <= w_ferr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_clk_count;
        w_index_nxt = r_bit_index;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        w_ferr_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_count_nxt = '0;
                end
            end
            START: begin
                if (r_clk_count == HALF_LAST) begin
                    w_count_nxt = '0;
                    w_index_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                        w_ferr_nxt  = 1'b1;
`endif
                    end
                end else begin
                    w_count_nxt = r_clk_count + 16'd1;
                end
            end
            DATA: begin
                if (r_clk_count == BIT_LAST) begin
                    w_shift_nxt[r_bit_index] = w_rx_s;
                    w_count_nxt = '0;
                    w_index_nxt = r_bit_index + 3'd1;
                    if (r_bit_index == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_count_nxt = r_clk_count + 16'd1;
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves room to catch an immediate next start.
                if (r_clk_count == BIT_LAST) begin
                    w_count_nxt = '0;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                        w_ferr_nxt  = 1'b1;
`endif
                    end
                end else begin
                    w_count_nxt = r_clk_count + 16'd1;
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit.
// Define UART_RX_FRAME_ERR_EN to also check the frame_err pulses.
module tb_uart_rx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    logic [7:0]  q_data[$];
    int unsigned q_cyc[$];
    int unsigned busy_cnt = 0;
    int unsigned overlap  = 0;
    int unsigned ferr_cnt = 0;

    uart_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
`ifdef UART_RX_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            q_data.push_back(data);
            q_cyc.push_back(cyc);
        end
        if (busy) busy_cnt++;
        if (valid && busy) overlap++;
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qd(input int unsigned i);
        if (i < q_data.size()) return q_data[i];
        return 8'hxx;
    endfunction

    function automatic int unsigned qc(input int unsigned i);
        if (i < q_cyc.size()) return q_cyc[i];
        return 0;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned base;
        int unsigned c0;
        int unsigned ferr0;
        int unsigned lat;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(data),  32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        reset = 1'b0;
        idle(5);

        // Single byte 0xA5: valid about 98 cycles after the start edge
        base = q_data.size();
        busy_cnt = 0;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(5);
        lat = qc(base) - c0;
        chk("a5_count", q_data.size() - base, 1);
        chk("a5_data",  32'(qd(base)), 32'hA5);
        chk("a5_lat",   32'(lat >= 97 && lat <= 99), 32'h1);
        chk("a5_busy",  32'(busy_cnt >= 94 && busy_cnt <= 96), 32'h1);
        chk("a5_hold",  32'(data), 32'hA5);

        // Back-to-back frames with no idle gap
        base = q_data.size();
        send_frame(8'h90, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h7F, 1'b1);
        idle(5);
        chk("b2b_count", q_data.size() - base, 3);
        chk("b2b_d0",    32'(qd(base)),     32'h90);
        chk("b2b_d1",    32'(qd(base + 1)), 32'h3C);
        chk("b2b_d2",    32'(qd(base + 2)), 32'h7F);
        chk("b2b_gap01", qc(base + 1) - qc(base),     100);
        chk("b2b_gap12", qc(base + 2) - qc(base + 1), 100);

        // Three-cycle glitch is rejected as a false start
        base = q_data.size();
        busy_cnt = 0;
        ferr0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_novalid", q_data.size() - base, 0);
        chk("glitch_busy",    32'(busy), 32'h0);
        chk("glitch_busylen", 32'(busy_cnt >= 1 && busy_cnt <= 7), 32'h1);
`ifdef UART_RX_FRAME_ERR_EN
        chk("glitch_ferr", ferr_cnt - ferr0, 1);
`endif

        // Framing error: stop bit low, line held low, then recovery
        base = q_data.size();
        ferr0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        idle(15);
        chk("ferr_novalid", q_data.size() - base, 0);
        chk("ferr_data",    32'(data), 32'h7F);
        chk("ferr_busy",    32'(busy), 32'h0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulse", ferr_cnt - ferr0, 1);
`endif
        base = q_data.size();
        send_frame(8'h12, 1'b1);
        idle(5);
        chk("ferr_next_count", q_data.size() - base, 1);
        chk("ferr_next_data",  32'(qd(base)), 32'h12);

        // Reset during data bit 4 of 0xFF
        base = q_data.size();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (45) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_busy",  32'(busy),  32'h0);
        chk("mrst_valid", 32'(valid), 32'h0);
        chk("mrst_data",  32'(data),  32'h00);
        idle(60);
        chk("mrst_novalid", q_data.size() - base, 0);
        send_frame(8'h81, 1'b1);
        idle(5);
        chk("mrst_next_count", q_data.size() - base, 1);
        chk("mrst_next_data",  32'(qd(base)), 32'h81);

        chk("valid_busy_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
